// File: rtl/mux_lut_logic_pipe_pkg.sv
// Shared types and truth-table constants for the mux-LUT logic pipeline.
package mux_lut_pkg;

    typedef logic [3:0] tt_t;

    // Truth tables indexed by {a, b}
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XNOR = 4'b1001;
    localparam logic [3:0] TT_ZERO = 4'b0000;
    localparam logic [3:0] TT_ONE  = 4'b1111;

endpackage

// File: rtl/mux_lut_logic_pipe_if.sv
// Stream bus for the mux-LUT logic pipeline: operand input, result output, status.
interface mux_lut_logic_pipe_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
);
    import mux_lut_pkg::*;

    logic             up_valid;
    logic             up_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    tt_t              tt;
    logic             down_valid;
    logic             down_ready;
    logic [WIDTH-1:0] res;
    logic             red_and;
    logic             red_or;
    logic             red_xor;
    logic [CNT_W-1:0] out_cnt;

    // Producer/consumer side
    modport master (
        output up_valid, a, b, tt, down_ready,
        input  up_ready, down_valid, res, red_and, red_or, red_xor, out_cnt
    );

    // Logic-unit side
    modport slave (
        input  up_valid, a, b, tt, down_ready,
        output up_ready, down_valid, res, red_and, red_or, red_xor, out_cnt
    );

endinterface

// File: rtl/mux.sv
// Basic 2:1 mux cell.
module mux (
    input  logic sel,
    input  logic d0,
    input  logic d1,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_lut2.sv
// One-bit 2-input LUT built from three 2:1 mux cells; y = tt[{a, b}].
module mux_lut2
    import mux_lut_pkg::*;
(
    input  logic a,
    input  logic b,
    input  tt_t  tt,
    output logic y
);

    logic lo;
    logic hi;

    // b picks within the a=0 half and the a=1 half
    mux u_mux_lo (
        .sel (b),
        .d0  (tt[0]),
        .d1  (tt[1]),
        .y   (lo)
    );

    mux u_mux_hi (
        .sel (b),
        .d0  (tt[2]),
        .d1  (tt[3]),
        .y   (hi)
    );

    mux u_mux_out (
        .sel (a),
        .d0  (lo),
        .d1  (hi),
        .y   (y)
    );

endmodule

// File: rtl/mux_lut_logic_pipe.sv
// Pipelined bitwise 2-input logic unit with valid/ready backpressure,
// result reduction flags and an output transfer counter.
module mux_lut_logic_pipe
    import mux_lut_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input logic                clk,
    input logic                rst,
    mux_lut_logic_pipe_if.slave bus
);

    logic [WIDTH-1:0] lut_out;
    logic [CNT_W-1:0] cnt_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lut
        mux_lut2 u_lut (
            .a  (bus.a[i]),
            .b  (bus.b[i]),
            .tt (bus.tt),
            .y  (lut_out[i])
        );
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             valid_q;
        logic [WIDTH-1:0] data_q;
        logic             ready;
        logic             load;
        logic             in_valid;
        logic [WIDTH-1:0] in_data;

        // Ready ripples back from the consumer through every stage
        if (k == DEPTH - 1) begin : g_last
            assign ready = bus.down_ready;
        end else begin : g_mid
            assign ready = g_stage[k+1].load;
        end

        if (k == 0) begin : g_first
            assign in_valid = bus.up_valid;
            assign in_data  = lut_out;
        end else begin : g_next
            assign in_valid = g_stage[k-1].valid_q;
            assign in_data  = g_stage[k-1].data_q;
        end

        assign load = !valid_q || ready;

        // Stage register: take the upstream beat (or a bubble) whenever free to move
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (load) begin
                valid_q <= in_valid;
                if (in_valid) begin
                    data_q <= in_data;
                end
            end
        end
    end

    // Count completed output transfers, wrapping naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (bus.down_valid && bus.down_ready) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.up_ready   = g_stage[0].load;
    assign bus.down_valid = g_stage[DEPTH-1].valid_q;
    assign bus.res        = g_stage[DEPTH-1].data_q;
    assign bus.red_and    = &g_stage[DEPTH-1].data_q;
    assign bus.red_or     = |g_stage[DEPTH-1].data_q;
    assign bus.red_xor    = ^g_stage[DEPTH-1].data_q;
    assign bus.out_cnt    = cnt_q;

endmodule

// File: tb/tb_mux_lut_logic_pipe.sv
// Directed bench for mux_lut_logic_pipe (WIDTH=8, DEPTH=2), with a CNT_W=4
// twin sharing the same stimulus to observe counter wrap.
module tb_mux_lut_logic_pipe;
    import mux_lut_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mux_lut_logic_pipe_if #(.WIDTH(8), .CNT_W(16)) bus ();
    mux_lut_logic_pipe_if #(.WIDTH(8), .CNT_W(4))  bus4 ();

    mux_lut_logic_pipe #(.WIDTH(8), .DEPTH(2), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mux_lut_logic_pipe #(.WIDTH(8), .DEPTH(2), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    assign bus4.up_valid   = bus.up_valid;
    assign bus4.a          = bus.a;
    assign bus4.b          = bus.b;
    assign bus4.tt         = bus.tt;
    assign bus4.down_ready = bus.down_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int recv;
        logic acc;
        logic emit;
        logic [7:0] held;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.up_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.tt = TT_ZERO;
        bus.down_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_down_valid", bus.down_valid, 0);
        chk("rst_res", bus.res, 0);
        chk("rst_red_and", bus.red_and, 0);
        chk("rst_out_cnt", bus.out_cnt, 0);
        rst = 1'b0;
        #1;
        chk("rst_up_ready", bus.up_ready, 1);

        // 1: AND, two-cycle latency
        step();
        bus.a = 8'hF0; bus.b = 8'hCC; bus.tt = TT_AND; bus.up_valid = 1'b1;
        step();
        bus.up_valid = 1'b0;
        chk("t1_not_yet", bus.down_valid, 0);
        step();
        chk("t1_valid", bus.down_valid, 1);
        chk("t1_res", bus.res, 8'hC0);
        chk("t1_red_and", bus.red_and, 0);
        chk("t1_red_or", bus.red_or, 1);
        chk("t1_red_xor", bus.red_xor, 0);
        chk("t1_cnt_before", bus.out_cnt, 0);
        step();
        chk("t1_cnt", bus.out_cnt, 1);
        chk("t1_drained", bus.down_valid, 0);

        // 2: XOR then NOR back to back, tt changes per beat
        bus.a = 8'h01; bus.b = 8'h00; bus.tt = TT_XOR; bus.up_valid = 1'b1;
        step();
        bus.tt = TT_NOR;
        step();
        bus.up_valid = 1'b0;
        chk("t2_xor_valid", bus.down_valid, 1);
        chk("t2_xor_res", bus.res, 8'h01);
        chk("t2_xor_par", bus.red_xor, 1);
        step();
        chk("t2_nor_valid", bus.down_valid, 1);
        chk("t2_nor_res", bus.res, 8'hFE);
        chk("t2_nor_par", bus.red_xor, 1);
        chk("t2_nor_and", bus.red_and, 0);
        step();
        chk("t2_cnt", bus.out_cnt, 3);

        // 3: constant tables
        bus.a = 8'h5A; bus.b = 8'h33; bus.tt = TT_ONE; bus.up_valid = 1'b1;
        step();
        bus.tt = TT_ZERO;
        step();
        bus.up_valid = 1'b0;
        chk("t3_one_res", bus.res, 8'hFF);
        chk("t3_one_and", bus.red_and, 1);
        step();
        chk("t3_zero_valid", bus.down_valid, 1);
        chk("t3_zero_res", bus.res, 8'h00);
        chk("t3_zero_or", bus.red_or, 0);
        step();
        chk("t3_cnt", bus.out_cnt, 5);

        // 4: 10-beat stream, consumer stalls on cycles 3..7; res = a via XOR with b=0
        sent = 0;
        recv = 0;
        held = '0;
        bus.b = 8'h00;
        bus.tt = TT_XOR;
        for (int c = 0; c < 40; c++) begin
            bus.down_ready = !(c >= 3 && c <= 7);
            bus.up_valid = (sent < 10);
            bus.a = 8'(sent + 1);
            #1;
            acc = bus.up_valid && bus.up_ready;
            emit = bus.down_valid && bus.down_ready;
            if (c == 3) held = bus.res;
            if (c > 3 && c <= 7) chk("t4_res_stable", bus.res, held);
            if (c == 7) begin
                chk("t4_stall_ready", bus.up_ready, 0);
                chk("t4_stored", sent - recv, 2);
            end
            if (emit) begin
                chk("t4_order", bus.res, 8'(recv + 1));
                recv++;
            end
            step();
            if (acc) sent++;
            if (recv == 10) break;
        end
        bus.up_valid = 1'b0;
        bus.down_ready = 1'b1;
        chk("t4_recv", recv, 10);
        chk("t4_sent", sent, 10);
        chk("t4_cnt", bus.out_cnt, 15);
        chk("t4_cnt4", bus4.out_cnt, 15);

        // 5: asynchronous reset with two beats in flight
        bus.a = 8'hAA; bus.up_valid = 1'b1; bus.down_ready = 1'b0;
        step();
        step();
        bus.up_valid = 1'b0;
        chk("t5_full", bus.down_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", bus.down_valid, 0);
        chk("t5_rst_cnt", bus.out_cnt, 0);
        chk("t5_rst_res", bus.res, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_up_ready", bus.up_ready, 1);
        bus.down_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t5_no_stale", bus.down_valid, 0);
        end
        chk("t5_cnt_zero", bus.out_cnt, 0);

        // 6: 17 transfers, 4-bit counter wraps to 1
        bus.tt = TT_ONE;
        bus.up_valid = 1'b1;
        for (int c = 0; c < 17; c++) step();
        bus.up_valid = 1'b0;
        step();
        step();
        step();
        chk("t6_cnt16", bus.out_cnt, 17);
        chk("t6_cnt4_wrap", bus4.out_cnt, 4'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
